// File: rtl/spi_flash_read_seq.sv
// Read-command sequencer around the spiv2 SPI master: pushes opcode/address/dummy words
// into the TX FIFO and drains the RX FIFO, delivering only flash data bytes. Option: SPI_FAST_READ_EN.
module spi_flash_read_seq #(
    parameter logic [7:0] CMD_READ = 8'h03,
    parameter int         LEN_W    = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [23:0]      addr,
    input  logic [LEN_W-1:0] len,
    output logic             busy,
    output logic             done,
    output logic [7:0]       data_out,
    output logic             data_valid,
    input  logic             data_ready,
    output logic [8:0]       tx_fifo_din,
    output logic             tx_fifo_wr,
    input  logic             tx_fifo_full,
    input  logic [7:0]       rx_fifo_dout,
    output logic             rx_fifo_rd,
    input  logic             rx_fifo_empty
);

`ifdef SPI_FAST_READ_EN
    localparam logic [7:0] OPCODE = 8'h0B;
    localparam int         HDR    = 5;
`else
    localparam logic [7:0] OPCODE = CMD_READ;
    localparam int         HDR    = 4;
`endif

    localparam logic [LEN_W:0] HDR_LEN = (LEN_W+1)'(HDR);
    localparam logic [LEN_W:0] CNT_ONE = (LEN_W+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [23:0]      addr_q;
    logic [LEN_W:0]   frame_len;
    logic [LEN_W:0]   tx_cnt;
    logic [LEN_W:0]   rx_cnt;
    logic             tx_push;
    logic             tx_last;
    logic [7:0]       tx_byte;
    logic             rx_in_hdr;
    logic             rx_avail;
    logic             accept;

    // Counters are one bit wider than len so header plus max length never wraps.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            addr_q    <= '0;
            frame_len <= '0;
            tx_cnt    <= '0;
            rx_cnt    <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                addr_q    <= addr;
                frame_len <= HDR_LEN + {1'b0, len};
                tx_cnt    <= '0;
                rx_cnt    <= '0;
            end else if (state == RUN) begin
                if (tx_push)
                    tx_cnt <= tx_cnt + CNT_ONE;
                if (rx_fifo_rd)
                    rx_cnt <= rx_cnt + CNT_ONE;
            end
        end
    end

    // Header bytes occupy TX slots 0..3; anything beyond is a zero dummy/clock byte.
    always_comb begin
        tx_byte = 8'h00;
        if (tx_cnt[LEN_W:2] == '0) begin
            unique case (tx_cnt[1:0])
                2'd0: tx_byte = OPCODE;
                2'd1: tx_byte = addr_q[23:16];
                2'd2: tx_byte = addr_q[15:8];
                2'd3: tx_byte = addr_q[7:0];
            endcase
        end
    end

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        tx_push     = 1'b0;
        tx_last     = 1'b0;
        rx_in_hdr   = 1'b0;
        rx_avail    = 1'b0;
        tx_fifo_wr  = 1'b0;
        tx_fifo_din = 9'h000;
        data_valid  = 1'b0;
        data_out    = 8'h00;
        rx_fifo_rd  = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    if (len != '0) begin
                        accept    = 1'b1;
                        state_nxt = RUN;
                    end else begin
                        state_nxt = DONE;
                    end
                end
            end
            RUN: begin
                busy        = 1'b1;
                tx_push     = (tx_cnt < frame_len) && !tx_fifo_full;
                tx_last     = (tx_cnt == frame_len - CNT_ONE);
                tx_fifo_wr  = tx_push;
                tx_fifo_din = tx_push ? {tx_last, tx_byte} : 9'h000;
                rx_in_hdr   = (rx_cnt < HDR_LEN);
                rx_avail    = (rx_cnt < frame_len) && !rx_fifo_empty;
                data_valid  = rx_avail && !rx_in_hdr;
                data_out    = data_valid ? rx_fifo_dout : 8'h00;
                rx_fifo_rd  = rx_avail && (rx_in_hdr || data_ready);
                if (rx_fifo_rd && (rx_cnt == frame_len - CNT_ONE))
                    state_nxt = DONE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: tb/tb_spi_flash_read_seq.sv
// Self-checking bench for spi_flash_read_seq: a FIFO/loopback environment plus a
// transaction-level model compared every cycle, and literal frame/data expectations.
module tb_spi_flash_read_seq;

`ifdef SPI_FAST_READ_EN
    localparam int         HDR = 5;
    localparam logic [7:0] OPC = 8'h0B;
`else
    localparam int         HDR = 4;
    localparam logic [7:0] OPC = 8'h03;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [23:0] addr;
    logic [15:0] len;
    logic        busy, done;
    logic [7:0]  data_out;
    logic        data_valid, data_ready;
    logic [8:0]  tx_fifo_din;
    logic        tx_fifo_wr, tx_fifo_full;
    logic [7:0]  rx_fifo_dout;
    logic        rx_fifo_rd, rx_fifo_empty;

    spi_flash_read_seq dut (
        .clk(clk), .rst(rst), .start(start), .addr(addr), .len(len),
        .busy(busy), .done(done), .data_out(data_out), .data_valid(data_valid),
        .data_ready(data_ready), .tx_fifo_din(tx_fifo_din), .tx_fifo_wr(tx_fifo_wr),
        .tx_fifo_full(tx_fifo_full), .rx_fifo_dout(rx_fifo_dout), .rx_fifo_rd(rx_fifo_rd),
        .rx_fifo_empty(rx_fifo_empty)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] rx_src [0:15];
    logic [7:0] rx_q [$];
    logic [8:0] tx_log [$];
    logic [7:0] data_log [$];
    logic [8:0] exp_tx [$];

    bit         m_busy, m_done;
    int         n_tot, tx_idx, rx_idx, env_tx_n;
    bit         pend_push, pend_pop;
    logic [7:0] pend_byte;

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_tx_log(input string name, input logic [8:0] w [8], input int n);
        check_output({name, "_count"}, tx_log.size(), n);
        for (int i = 0; i < n && i < tx_log.size(); i++)
            check_output({name, "_word"}, tx_log[i], w[i]);
    endtask

    task automatic check_data_log(input string name, input logic [7:0] b [4], input int n);
        check_output({name, "_count"}, data_log.size(), n);
        for (int i = 0; i < n && i < data_log.size(); i++)
            check_output({name, "_byte"}, data_log[i], b[i]);
    endtask

    // FIFO/spiv2 stand-in: every accepted TX word returns the next rx_src byte.
    always begin
        @(posedge clk);
        #1;
        if (rst) begin
            if (pend_pop && rx_q.size() > 0) void'(rx_q.pop_front());
            if (pend_push) rx_q.push_back(pend_byte);
        end
        rx_fifo_empty = (rx_q.size() == 0);
        rx_fifo_dout  = (rx_q.size() > 0) ? rx_q[0] : 8'hEE;
    end

    // Transaction model: frame = opcode, address, optional dummy, len zero words;
    // the first HDR returned bytes are dropped, the rest are delivered in order.
    always @(negedge clk) begin
        bit e_wr, e_hdr, e_valid, e_rd, nd, acc;
        if (!rst) begin
            check_output("rst_busy", busy, 0);
            check_output("rst_done", done, 0);
            check_output("rst_tx_wr", tx_fifo_wr, 0);
            check_output("rst_tx_din", tx_fifo_din, 0);
            check_output("rst_valid", data_valid, 0);
            check_output("rst_data", data_out, 0);
            check_output("rst_rx_rd", rx_fifo_rd, 0);
            m_busy = 0; m_done = 0; n_tot = 0; tx_idx = 0; rx_idx = 0; env_tx_n = 0;
            pend_push = 0; pend_pop = 0;
        end else begin
            e_wr    = m_busy && tx_idx < n_tot && !tx_fifo_full;
            e_hdr   = rx_idx < HDR;
            e_valid = m_busy && !e_hdr && rx_idx < n_tot && !rx_fifo_empty;
            e_rd    = m_busy && rx_idx < n_tot && !rx_fifo_empty && (e_hdr || data_ready);
            check_output("busy", busy, m_busy);
            check_output("done", done, m_done);
            check_output("tx_wr", tx_fifo_wr, e_wr);
            check_output("data_valid", data_valid, e_valid);
            check_output("rx_rd", rx_fifo_rd, e_rd);
            if (e_wr && tx_fifo_wr)
                check_output("tx_word", tx_fifo_din, exp_tx[tx_idx]);
            if (e_valid)
                check_output("data_out", data_out, rx_src[rx_idx]);
            pend_push = 0;
            pend_pop  = rx_fifo_rd;
            if (tx_fifo_wr) begin
                tx_log.push_back(tx_fifo_din);
                pend_push = 1;
                pend_byte = (env_tx_n < 16) ? rx_src[env_tx_n] : 8'hEE;
                env_tx_n++;
            end
            if (data_valid && data_ready && rx_fifo_rd)
                data_log.push_back(data_out);
            acc = !m_busy && !m_done && start;
            nd  = 0;
            if (e_wr) tx_idx++;
            if (e_rd) begin
                rx_idx++;
                if (rx_idx == n_tot) begin
                    m_busy = 0;
                    nd = 1;
                end
            end
            if (acc) begin
                if (len != 0) begin
                    exp_tx.delete();
                    exp_tx.push_back({1'b0, OPC});
                    exp_tx.push_back({1'b0, addr[23:16]});
                    exp_tx.push_back({1'b0, addr[15:8]});
                    exp_tx.push_back({1'b0, addr[7:0]});
                    if (HDR == 5) exp_tx.push_back(9'h000);
                    for (int i = 0; i < int'(len); i++)
                        exp_tx.push_back({(i == int'(len) - 1), 8'h00});
                    n_tot = HDR + int'(len);
                    tx_idx = 0; rx_idx = 0; env_tx_n = 0;
                    m_busy = 1;
                end else begin
                    nd = 1;
                end
            end
            m_done = nd;
        end
    end

    task automatic apply_stimulus(input logic [23:0] a, input logic [15:0] l);
        @(posedge clk); #1;
        addr = a; len = l; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        bit seen = 0;
        for (int k = 0; k < 300; k++) begin
            @(negedge clk);
            if (done) begin seen = 1; break; end
        end
        check_output(name, seen, 1);
    endtask

    task automatic wait_tx(input int n);
        bit seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (tx_log.size() >= n) begin seen = 1; break; end
        end
        check_output("wait_tx_pushes", seen, 1);
    endtask

    initial begin
        bit seen;
        rst = 1'b0; start = 1'b0; addr = '0; len = '0;
        data_ready = 1'b1; tx_fifo_full = 1'b0;
        rx_fifo_empty = 1'b1; rx_fifo_dout = 8'hEE;
        pend_push = 0; pend_pop = 0;
        for (int i = 0; i < 16; i++) rx_src[i] = 8'h00;
        repeat (3) @(posedge clk);
        #3 rst = 1'b1;

        // Basic read, plus an ignored start while busy
        rx_src[0] = 8'hAA; rx_src[1] = 8'hBB; rx_src[2] = 8'hCC; rx_src[3] = 8'hDD;
        rx_src[4] = 8'h5A; rx_src[5] = 8'hA5; rx_src[6] = 8'h77;
        tx_log.delete(); data_log.delete();
        apply_stimulus(24'h123456, 16'd2);
        repeat (2) @(posedge clk);
        apply_stimulus(24'hFFFFFF, 16'd5);
        wait_done("t1_done");
        @(negedge clk);
        check_output("t1_done_pulse", done, 0);
        check_output("t1_busy_after", busy, 0);
`ifdef SPI_FAST_READ_EN
        check_tx_log("t1_tx", '{9'h00B, 9'h012, 9'h034, 9'h056, 9'h000, 9'h000, 9'h100, 9'h000}, 7);
        check_data_log("t1_data", '{8'hA5, 8'h77, 8'h00, 8'h00}, 2);
`else
        check_tx_log("t1_tx", '{9'h003, 9'h012, 9'h034, 9'h056, 9'h000, 9'h100, 9'h000, 9'h000}, 6);
        check_data_log("t1_data", '{8'h5A, 8'hA5, 8'h00, 8'h00}, 2);
`endif

        // TX FIFO full for 10 cycles mid-header
        for (int i = 0; i < 16; i++) rx_src[i] = 8'h10 + 8'(i);
        tx_log.delete(); data_log.delete();
        apply_stimulus(24'h00A0B0, 16'd1);
        wait_tx(2);
        @(posedge clk); #1 tx_fifo_full = 1'b1;
        repeat (10) begin
            @(negedge clk);
            check_output("t2_no_wr_full", tx_fifo_wr, 0);
            @(posedge clk); #1;
        end
        tx_fifo_full = 1'b0;
        wait_done("t2_done");
`ifdef SPI_FAST_READ_EN
        check_tx_log("t2_tx", '{9'h00B, 9'h000, 9'h0A0, 9'h0B0, 9'h000, 9'h100, 9'h000, 9'h000}, 6);
        check_data_log("t2_data", '{8'h15, 8'h00, 8'h00, 8'h00}, 1);
`else
        check_tx_log("t2_tx", '{9'h003, 9'h000, 9'h0A0, 9'h0B0, 9'h100, 9'h000, 9'h000, 9'h000}, 5);
        check_data_log("t2_data", '{8'h14, 8'h00, 8'h00, 8'h00}, 1);
`endif

        // Consumer backpressure with data waiting
        for (int i = 0; i < 16; i++) rx_src[i] = 8'h20 + 8'(i);
        tx_log.delete(); data_log.delete();
        @(posedge clk); #1 data_ready = 1'b0;
        apply_stimulus(24'h000001, 16'd3);
        seen = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (data_valid) begin seen = 1; break; end
        end
        check_output("t3_valid_seen", seen, 1);
        repeat (5) begin
            @(negedge clk);
            check_output("t3_valid_hold", data_valid, 1);
            check_output("t3_no_rd", rx_fifo_rd, 0);
            check_output("t3_data_stable", data_out, rx_src[HDR]);
        end
        @(posedge clk); #1 data_ready = 1'b1;
        wait_done("t3_done");
`ifdef SPI_FAST_READ_EN
        check_data_log("t3_data", '{8'h25, 8'h26, 8'h27, 8'h00}, 3);
`else
        check_data_log("t3_data", '{8'h24, 8'h25, 8'h26, 8'h00}, 3);
`endif

        // Zero-length request
        tx_log.delete();
        @(posedge clk); #1;
        addr = 24'h555555; len = 16'd0; start = 1'b1;
        @(negedge clk);
        check_output("t4_done_early", done, 0);
        @(posedge clk); #1 start = 1'b0;
        @(negedge clk);
        check_output("t4_done", done, 1);
        check_output("t4_busy", busy, 0);
        @(negedge clk);
        check_output("t4_done_gone", done, 0);
        check_output("t4_no_tx", tx_log.size(), 0);

        // Reset mid-transaction, then a clean frame
        for (int i = 0; i < 16; i++) rx_src[i] = 8'h30 + 8'(i);
        tx_log.delete(); data_log.delete();
        apply_stimulus(24'h778899, 16'd4);
        wait_tx(3);
        @(posedge clk); #2 rst = 1'b0;
        #1;
        check_output("t5_busy0", busy, 0);
        check_output("t5_wr0", tx_fifo_wr, 0);
        check_output("t5_din0", tx_fifo_din, 0);
        check_output("t5_rd0", rx_fifo_rd, 0);
        check_output("t5_valid0", data_valid, 0);
        rx_q.delete();
        rx_fifo_empty = 1'b1;
        @(posedge clk); @(posedge clk); #3 rst = 1'b1;
        tx_log.delete(); data_log.delete();
        apply_stimulus(24'hABCDEF, 16'd1);
        wait_done("t5_done");
`ifdef SPI_FAST_READ_EN
        check_tx_log("t5_tx", '{9'h00B, 9'h0AB, 9'h0CD, 9'h0EF, 9'h000, 9'h100, 9'h000, 9'h000}, 6);
        check_data_log("t5_data", '{8'h35, 8'h00, 8'h00, 8'h00}, 1);
`else
        check_tx_log("t5_tx", '{9'h003, 9'h0AB, 9'h0CD, 9'h0EF, 9'h100, 9'h000, 9'h000, 9'h000}, 5);
        check_data_log("t5_data", '{8'h34, 8'h00, 8'h00, 8'h00}, 1);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_flash_read_seq.md
Name: spi_flash_read_seq

Overview:
- Command sequencer directly upstream and downstream of the spiv2 SPI master.
- Turns a read request (start, 24-bit address, byte count) into a stream of 9-bit words pushed into the TX FIFO that spiv2 drains.
- Pops the matching RX FIFO bytes that spiv2 fills, discards header bytes and delivers the flash data bytes with valid/ready handshake.
- Bit 8 of each TX word marks the last byte of a frame; spiv2 releases cs after that byte.

Parameters:
- CMD_READ, 8'h03, flash read opcode sent as the first byte.
- LEN_W, 16, width of the byte-count input and counters.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- start  in  1  request pulse; sampled only in IDLE.
- addr  in  24  flash start address, latched on accepted start.
- len  in  LEN_W  number of data bytes to read, latched on accepted start.
- busy  out  1  high from accepted start until done.
- done  out  1  one-cycle pulse when the transaction completes.
- data_out  out  8  received flash byte.
- data_valid  out  1  data_out is valid.
- data_ready  in  1  consumer accepts data_out.
- tx_fifo_din  out  9  word to spiv2: {last, byte}.
- tx_fifo_wr  out  1  TX FIFO push strobe.
- tx_fifo_full  in  1  TX FIFO full.
- rx_fifo_dout  in  8  RX FIFO head byte (first-word-fall-through, valid while not empty).
- rx_fifo_rd  out  1  RX FIFO pop strobe.
- rx_fifo_empty  in  1  RX FIFO empty.

Behaviour:
- Reset (rst=0, async): state IDLE, counters 0, busy=0, done=0, data_valid=0, tx_fifo_wr=0, rx_fifo_rd=0, tx_fifo_din=0, data_out=0.
- Header: H = 4 bytes (opcode + 3 address bytes). Total frame N = H + len words.
- States:
  - IDLE: start=1 with len!=0 latches addr/len, clears tx_cnt/rx_cnt and moves to RUN. busy rises the next cycle.
  - RUN: TX push and RX drain run concurrently from independent counters.
  - DONE: pulses done for one cycle, drops busy and returns to IDLE.
- start with len=0: no FIFO traffic; done pulses the cycle after start; busy stays 0.
- TX push rules:
  - tx_fifo_wr=1 only when tx_cnt<N and tx_fifo_full=0. tx_cnt increments per push.
  - Word order: {0,CMD_READ}, then {0,addr[23:16]}, {0,addr[15:8]}, {0,addr[7:0]}, then len dummy words {0,8'h00}.
  - The final word (tx_cnt=N-1) carries bit8=1; no other word does.
- RX drain rules (every TX byte yields one RX byte):
  - rx_cnt<H: rx_fifo_rd = !rx_fifo_empty; byte discarded; data_valid=0.
  - H≤rx_cnt<N: data_valid = !rx_fifo_empty, data_out = rx_fifo_dout, rx_fifo_rd = data_valid & data_ready. Backpressure holds data_out stable.
  - rx_cnt increments on every pop.
- Completion: the pop with rx_cnt=N-1 moves RUN to DONE. done aligns with the cycle after the final data handshake.
- Full TX FIFO stalls pushing only; RX drain continues. Empty RX FIFO stalls drain only.
- start while busy is ignored; addr/len changes while busy have no effect.
- Counters are LEN_W+1 bits wide, so len=2^LEN_W-1 does not wrap.
- Reset mid-transaction aborts immediately. FIFOs and spiv2 are not flushed by this block; the system resets them on the same rst.

Optional Feature:
- Macro: SPI_FAST_READ_EN.
- Defined: opcode 8'h0B, H=5 (one extra dummy {0,8'h00} after the address, before the data words); 5 RX bytes discarded.
- Undefined: CMD_READ opcode, H=4, as above.

Test Plan:
- Basic read: start, addr=24'h123456, len=2, FIFOs never full/empty-stalled -> TX words 0x003,0x012,0x034,0x056,0x000,0x100. RX bytes AA,BB,CC,DD,5A,A5 -> data_out 5A then A5; done one pulse; busy low afterwards.
- TX backpressure: tx_fifo_full=1 for 10 cycles mid-header -> no tx_fifo_wr while full; word sequence unchanged and complete.
- RX backpressure: len=3, data_ready=0 for 5 cycles with RX FIFO non-empty -> data_valid held, data_out stable, no rx_fifo_rd; all 3 bytes delivered in order.
- len=0 start -> no tx_fifo_wr, done pulses next cycle, busy never asserted.
- Reset mid-operation: rst low after 3 TX pushes -> all outputs 0 immediately. A new start after release produces a clean frame from the opcode.
- With SPI_FAST_READ_EN, addr=0, len=1 -> TX 0x00B,0x000,0x000,0x000,0x000,0x100. The first 5 RX bytes are discarded; the 6th appears on data_out.
